// File: rtl/cu_pipe_ctrl_pkg.sv
// Shared encodings for the pipelined control unit: opcodes, ALU operations,
// jump kinds and the memory/writeback control bundle carried down the pipe.
package cu_pipe_ctrl_pkg;

    localparam int OPC_W = 6;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03,
        OP_CMP  = 6'h04, OP_CMPS = 6'h05, OP_SL   = 6'h06, OP_SR   = 6'h07,
        OP_OR   = 6'h08, OP_AND  = 6'h09, OP_MW   = 6'h10, OP_MR   = 6'h11,
        OP_MOV  = 6'h20, OP_MOVI = 6'h21, OP_JMP  = 6'h22, OP_JB   = 6'h23
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_CMP = 3'd2, ALU_CMPS = 3'd3,
        ALU_SL  = 3'd4, ALU_SR  = 3'd5, ALU_OR  = 3'd6, ALU_AND  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        J_NONE = 2'b00,
        J_JMP  = 2'b10,
        J_JB   = 2'b11
    } jump_e;

    typedef struct packed {
        logic reg_wre;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } mem_ctrl_t;

endpackage

// File: rtl/cu_pipe_ctrl_if.sv
// Core-side handshake bundle of the control unit: ID instruction fields,
// branch/exception inputs and the per-stage control outputs.
interface cu_pipe_ctrl_if #(
    parameter int OP_W    = 6,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 3
);
    logic               id_valid;
    logic [OP_W-1:0]    id_opcode;
    logic [REG_AW-1:0]  id_rs;
    logic [REG_AW-1:0]  id_rt;
    logic [REG_AW-1:0]  id_rd;
    logic               ex_br_taken;
    logic               exc_ack;

    logic               stall_out;
    logic               flush_out;
    logic               ex_valid;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic               ex_ext_sign;
    logic [1:0]         ex_jump;
    logic               mem_valid;
    logic               mem_read;
    logic               mem_write;
    logic               wb_valid;
    logic               wb_reg_wre;
    logic               wb_mem_to_reg;
    logic [REG_AW-1:0]  wb_waddr;
    logic               exc_valid;
    logic [OP_W-1:0]    exc_opcode;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt, id_rd, ex_br_taken, exc_ack,
        input  stall_out, flush_out, ex_valid, ex_alu_op, ex_ext_sign, ex_jump,
               mem_valid, mem_read, mem_write, wb_valid, wb_reg_wre, wb_mem_to_reg,
               wb_waddr, exc_valid, exc_opcode
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, id_rd, ex_br_taken, exc_ack,
        output stall_out, flush_out, ex_valid, ex_alu_op, ex_ext_sign, ex_jump,
               mem_valid, mem_read, mem_write, wb_valid, wb_reg_wre, wb_mem_to_reg,
               wb_waddr, exc_valid, exc_opcode
    );
endinterface

// File: rtl/cu_pipe_ctrl_decode.sv
// Combinational ID-stage decoder: opcode to legality and control fields.
module cu_pipe_ctrl_decode
    import cu_pipe_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic [OP_W-1:0]    i_opcode,
    output logic               o_legal,
    output logic               o_reg_wre,
    output logic               o_waddr_sel,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic               o_ext_sign,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_mem_to_reg,
    output logic [1:0]         o_jump
);
    logic [OPC_W-1:0] w_op;
    logic             w_hi_zero;
    logic [2:0]       w_alu;

    assign w_op      = i_opcode[OPC_W-1:0];
    assign w_hi_zero = ((i_opcode >> OPC_W) == '0);

    always_comb begin
        o_legal     = 1'b0;
        w_alu       = ALU_ADD;
        o_ext_sign  = 1'b0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_jump      = J_NONE;
        if (w_hi_zero) begin
            o_legal = 1'b1;
            case (w_op)
                OP_ADD, OP_MOV, OP_MR, OP_MW: begin
                    o_mem_read  = (w_op == OP_MR);
                    o_mem_write = (w_op == OP_MW);
                end
                OP_ADDI, OP_MOVI: o_ext_sign = 1'b1;
                OP_SUB:           w_alu = ALU_SUB;
                OP_SUBI: begin
                    w_alu      = ALU_SUB;
                    o_ext_sign = 1'b1;
                end
                OP_CMP:  w_alu = ALU_CMP;
                OP_CMPS: w_alu = ALU_CMPS;
                OP_SL:   w_alu = ALU_SL;
                OP_SR:   w_alu = ALU_SR;
                OP_OR:   w_alu = ALU_OR;
                OP_AND:  w_alu = ALU_AND;
                OP_JMP:  o_jump = J_JMP;
                OP_JB: begin
                    o_jump = J_JB;
                    w_alu  = ALU_CMP;
                end
                default: o_legal = 1'b0;
            endcase
        end
        o_reg_wre = o_legal & ~o_mem_write & (o_jump == J_NONE);
    end

    // Immediate forms are exactly the sign-extending ones and write rt.
    assign o_waddr_sel  = o_ext_sign;
    assign o_mem_to_reg = o_mem_read;
    assign o_alu_op     = ALUOP_W'(w_alu);

endmodule

// File: rtl/cu_pipe_ctrl.sv
// Pipelined control unit: ID decode, EX/MEM/WB control registers, load-use
// stall, jump/branch flushes and a latched illegal-opcode exception.
module cu_pipe_ctrl
    import cu_pipe_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    cu_pipe_ctrl_if.slave bus
);
    logic               w_legal, w_reg_wre, w_waddr_sel, w_ext_sign;
    logic               w_mem_read, w_mem_write, w_mem_to_reg;
    logic [ALUOP_W-1:0] w_alu_op;
    logic [1:0]         w_jump;
    logic               w_ex_flush, w_load_use, w_id_live, w_issue, w_raise;
    mem_ctrl_t          w_id_ctrl;
    logic [REG_AW-1:0]  w_id_waddr;

    logic               r_ex_valid, r_ex_ext_sign;
    logic [ALUOP_W-1:0] r_ex_alu_op;
    logic [1:0]         r_ex_jump;
    mem_ctrl_t          r_ex_ctrl, r_mem_ctrl;
    logic [REG_AW-1:0]  r_ex_waddr, r_mem_waddr, r_wb_waddr;
    logic               r_mem_valid, r_wb_valid, r_wb_reg_wre, r_wb_mem_to_reg;
    logic               r_exc_valid;
    logic [OP_W-1:0]    r_exc_opcode;

    cu_pipe_ctrl_decode #(
        .OP_W    (OP_W),
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .i_opcode     (bus.id_opcode),
        .o_legal      (w_legal),
        .o_reg_wre    (w_reg_wre),
        .o_waddr_sel  (w_waddr_sel),
        .o_alu_op     (w_alu_op),
        .o_ext_sign   (w_ext_sign),
        .o_mem_read   (w_mem_read),
        .o_mem_write  (w_mem_write),
        .o_mem_to_reg (w_mem_to_reg),
        .o_jump       (w_jump)
    );

    assign w_ex_flush = r_ex_valid & (r_ex_jump == J_JB) & bus.ex_br_taken;
    assign w_load_use = bus.id_valid & r_ex_valid & r_ex_ctrl.mem_read &
                        ((r_ex_waddr == bus.id_rs) | (r_ex_waddr == bus.id_rt));
    // A live ID instruction is neither killed by a taken branch nor frozen by a pending exception.
    assign w_id_live  = bus.id_valid & ~w_ex_flush & ~r_exc_valid;
    assign w_issue    = w_id_live & w_legal & ~w_load_use;
    assign w_raise    = w_id_live & ~w_legal;

    assign bus.stall_out = ~w_ex_flush & (r_exc_valid | w_load_use);
    assign bus.flush_out = w_ex_flush | (w_issue & (w_jump == J_JMP));

    assign w_id_ctrl  = '{reg_wre: w_reg_wre, mem_read: w_mem_read,
                          mem_write: w_mem_write, mem_to_reg: w_mem_to_reg};
    assign w_id_waddr = w_waddr_sel ? bus.id_rt : bus.id_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid      <= 1'b0;
            r_ex_alu_op     <= '0;
            r_ex_ext_sign   <= 1'b0;
            r_ex_jump       <= J_NONE;
            r_ex_ctrl       <= '0;
            r_ex_waddr      <= '0;
            r_mem_valid     <= 1'b0;
            r_mem_ctrl      <= '0;
            r_mem_waddr     <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_reg_wre    <= 1'b0;
            r_wb_mem_to_reg <= 1'b0;
            r_wb_waddr      <= '0;
            r_exc_valid     <= 1'b0;
            r_exc_opcode    <= '0;
        end else begin
            r_ex_valid    <= w_issue;
            r_ex_alu_op   <= w_issue ? w_alu_op   : '0;
            r_ex_ext_sign <= w_issue & w_ext_sign;
            r_ex_jump     <= w_issue ? w_jump     : J_NONE;
            r_ex_ctrl     <= w_issue ? w_id_ctrl  : '0;
            r_ex_waddr    <= w_issue ? w_id_waddr : '0;

            r_mem_valid <= r_ex_valid;
            r_mem_ctrl  <= r_ex_ctrl;
            r_mem_waddr <= r_ex_waddr;

            r_wb_valid      <= r_mem_valid;
            r_wb_reg_wre    <= r_mem_ctrl.reg_wre;
            r_wb_mem_to_reg <= r_mem_ctrl.mem_to_reg;
            r_wb_waddr      <= r_mem_waddr;

            if (w_raise) begin
                r_exc_valid  <= 1'b1;
                r_exc_opcode <= bus.id_opcode;
            end else if (r_exc_valid && bus.exc_ack) begin
                r_exc_valid <= 1'b0;
            end
        end
    end

    assign bus.ex_valid      = r_ex_valid;
    assign bus.ex_alu_op     = r_ex_alu_op;
    assign bus.ex_ext_sign   = r_ex_ext_sign;
    assign bus.ex_jump       = r_ex_jump;
    assign bus.mem_valid     = r_mem_valid;
    assign bus.mem_read      = r_mem_ctrl.mem_read;
    assign bus.mem_write     = r_mem_ctrl.mem_write;
    assign bus.wb_valid      = r_wb_valid;
    assign bus.wb_reg_wre    = r_wb_reg_wre;
    assign bus.wb_mem_to_reg = r_wb_mem_to_reg;
    assign bus.wb_waddr      = r_wb_waddr;
    assign bus.exc_valid     = r_exc_valid;
    assign bus.exc_opcode    = r_exc_opcode;

endmodule
